read_line_assembler: RTL



---
 rtl/read_line_assembler_pkg.sv | 18 +
 rtl/read_line_assembler_sync_fifo.sv | 47 ++++
 rtl/read_line_assembler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/read_line_assembler_pkg.sv
// Shared types and constants for the read-line assembler and its future struct-based hookup.
package read_line_assembler_pkg;

    localparam int unsigned CACHELINE_HALF_BITS = 512;
    localparam int unsigned TAG_W               = 8;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_WAIT_HI = 1'b1
    } asm_state_t;

    typedef struct packed {
        logic                               valid;
        logic [TAG_W-1:0]                   tag;
        logic [2*CACHELINE_HALF_BITS-1:0]   data;
    } ReadLineOut;

endpackage

// File: rtl/read_line_assembler_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; push while full is accepted only when a pop frees a slot.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_wr;
    logic             w_rd;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign o_count = r_wptr - r_rptr;
    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign o_empty = (r_wptr == r_rptr);
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/read_line_assembler.sv
// Pairs LSB/MSB cacheline halves by tag; read lines go to a FIFO, WED lines to a holding register.
module read_line_assembler #(
    parameter int unsigned TAG_W        = read_line_assembler_pkg::TAG_W,
    parameter int unsigned HALF_W       = read_line_assembler_pkg::CACHELINE_HALF_BITS,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned AFULL_THRESH = 12,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                enabled_in,
    input  logic                lo_valid,
    input  logic                lo_read,
    input  logic                lo_wed,
    input  logic [TAG_W-1:0]    lo_tag,
    input  logic [HALF_W-1:0]   lo_data,
    input  logic                hi_valid,
    input  logic [TAG_W-1:0]    hi_tag,
    input  logic [HALF_W-1:0]   hi_data,
    output logic                line_valid,
    input  logic                line_ready,
    output logic [TAG_W-1:0]    line_tag,
    output logic [2*HALF_W-1:0] line_data,
    output logic                wed_valid,
    output logic [2*HALF_W-1:0] wed_data,
    output logic                almost_full,
    output logic [2:0]          assemble_error
);

    import read_line_assembler_pkg::*;

    localparam int unsigned LINE_W  = 2*HALF_W;
    localparam int unsigned ENTRY_W = TAG_W + LINE_W;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT+1);
    localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH)+1;

    asm_state_t          r_state;
    asm_state_t          w_state_next;
    logic                r_enabled;
    logic [TAG_W-1:0]    r_cap_tag;
    logic [HALF_W-1:0]   r_cap_data;
    logic                r_cap_read;
    logic                r_cap_wed;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                r_wed_valid;
    logic [LINE_W-1:0]   r_wed_data;
    logic                r_afull;
    logic [2:0]          r_err;

    logic                w_load_cap;
    logic                w_push;
    logic                w_wed_load;
    logic                w_set_orphan;
    logic                w_set_timeout;
    logic                w_pop;
    logic                w_push_ok;
    logic                w_overflow;
    logic [ENTRY_W-1:0]  w_head;
    logic [OCC_W-1:0]    w_count;
    logic [OCC_W-1:0]    w_count_next;
    logic                w_full;
    logic                w_empty;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_load_cap    = 1'b0;
        w_push        = 1'b0;
        w_wed_load    = 1'b0;
        w_set_orphan  = 1'b0;
        w_set_timeout = 1'b0;
        if (!r_enabled) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (hi_valid) w_set_orphan = 1'b1;
                    if (lo_valid) begin
                        w_load_cap   = 1'b1;
                        w_state_next = S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (hi_valid) begin
                        if (hi_tag == r_cap_tag) begin
                            w_push     = r_cap_read;
                            w_wed_load = r_cap_wed;
                        end else begin
                            w_set_orphan = 1'b1;
                        end
                        if (lo_valid) w_load_cap = 1'b1;
                        else          w_state_next = S_IDLE;
                    end else if (lo_valid) begin
                        w_set_orphan = 1'b1;
                        w_load_cap   = 1'b1;
                    end else if (w_cnt_inc >= CNT_W'(TIMEOUT)) begin
                        w_set_timeout = 1'b1;
                        w_state_next  = S_IDLE;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
            if (w_load_cap) w_cnt_next = '0;
        end
    end

    assign w_pop        = line_valid && line_ready;
    assign w_push_ok    = w_push && (!w_full || w_pop);
    assign w_overflow   = w_push && w_full && !w_pop;
    assign w_count_next = w_count + OCC_W'(w_push_ok) - OCC_W'(w_pop);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_enabled   <= 1'b0;
            r_state     <= S_IDLE;
            r_cap_tag   <= '0;
            r_cap_data  <= '0;
            r_cap_read  <= 1'b0;
            r_cap_wed   <= 1'b0;
            r_cnt       <= '0;
            r_wed_valid <= 1'b0;
            r_wed_data  <= '0;
            r_afull     <= 1'b0;
            r_err       <= '0;
        end else begin
            r_enabled   <= enabled_in;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            if (w_load_cap) begin
                r_cap_tag  <= lo_tag;
                r_cap_data <= lo_data;
                r_cap_read <= lo_read;
                r_cap_wed  <= lo_wed;
            end
            r_wed_valid <= w_wed_load;
            if (w_wed_load) r_wed_data <= {hi_data, r_cap_data};
            r_afull     <= (w_count_next >= OCC_W'(AFULL_THRESH));
            r_err       <= r_err | {w_overflow, w_set_timeout, w_set_orphan};
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_cap_tag, hi_data, r_cap_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // FIFO storage is not reset, so the head is masked to keep outputs zero when empty.
    assign line_valid     = !w_empty;
    assign line_tag       = line_valid ? w_head[ENTRY_W-1 -: TAG_W] : '0;
    assign line_data      = line_valid ? w_head[LINE_W-1:0] : '0;
    assign wed_valid      = r_wed_valid;
    assign wed_data       = r_wed_data;
    assign almost_full    = r_afull;
    assign assemble_error = r_err;

endmodule
